// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain stage for a bank of FIFOs: pops at most one queue per cycle
// into a single valid/ready output register tagged with the source queue index.
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef ARB_QWID
`define ARB_QWID 2
`endif

module fifo_rr_arbiter #(
    parameter int WIDTH = `FIFO_DWIDTH,
    parameter int QWID  = `ARB_QWID,
    parameter int NQ    = 2**QWID
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NQ-1:0]       q_empty,
    input  logic [NQ*WIDTH-1:0] q_data,
    output logic [NQ-1:0]       q_pop,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [WIDTH-1:0]    out_data,
    output logic [QWID-1:0]     out_qid
);
    localparam int              NSLOT  = 2**QWID;
    localparam logic [QWID-1:0] LAST_Q = QWID'(NQ - 1);

    logic [QWID-1:0]  rr_ptr;
    logic [NSLOT-1:0] req;
    logic [WIDTH-1:0] words [NSLOT];
    logic [QWID-1:0]  gnt;
    logic [QWID:0]    cand;
    logic             any_req;
    logic             slot_free;
    logic             load;

    // Padding to a full 2**QWID slots keeps every index exactly QWID bits wide.
    always_comb begin
        req         = '0;
        req[NQ-1:0] = ~q_empty;
    end

    for (genvar i = 0; i < NSLOT; i++) begin : g_word
        if (i < NQ) begin : g_live
            assign words[i] = q_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign words[i] = '0;
        end
    end

    // Scan from the far end back to rr_ptr so the last hit is the nearest request.
    always_comb begin
        gnt     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = NQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (QWID+1)'(k);
            if (cand >= (QWID+1)'(NQ)) begin
                cand = cand - (QWID+1)'(NQ);
            end
            if (req[cand[QWID-1:0]]) begin
                gnt     = cand[QWID-1:0];
                any_req = 1'b1;
            end
        end
    end

    assign slot_free = !out_vld || out_rdy;
    // rst gates the pop so nothing leaves the FIFOs while reset is held.
    assign load      = rst && slot_free && any_req;

    always_comb begin
        q_pop = '0;
        if (load) begin
            q_pop = NQ'(1) << gnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_qid  <= '0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_data <= words[gnt];
            out_qid  <= gnt;
            rr_ptr   <= (gnt == LAST_Q) ? '0 : gnt + 1'b1;
        end else if (out_vld && out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with four 8-bit queues holding fixed head words.
module tb_fifo_rr_arbiter;
    localparam int WIDTH = 8;
    localparam int QWID  = 2;
    localparam int NQ    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NQ-1:0]       q_empty;
    logic [NQ*WIDTH-1:0] q_data;
    logic [NQ-1:0]       q_pop;
    logic                out_vld;
    logic                out_rdy;
    logic [WIDTH-1:0]    out_data;
    logic [QWID-1:0]     out_qid;

    logic [WIDTH-1:0] dat [NQ];
    int n_checks = 0;
    int n_errors = 0;

    fifo_rr_arbiter #(.WIDTH(WIDTH), .QWID(QWID), .NQ(NQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .q_empty  (q_empty),
        .q_data   (q_data),
        .q_pop    (q_pop),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_qid  (out_qid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int q);
        check({tag, "_vld"}, 32'(out_vld), 32'd1);
        check({tag, "_qid"}, 32'(out_qid), 32'(q));
        check({tag, "_data"}, 32'(out_data), 32'(dat[q]));
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        q_empty = 4'hF;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants [4];
        dat[0] = 8'h11;
        dat[1] = 8'h22;
        dat[2] = 8'hA5;
        dat[3] = 8'h44;
        q_data  = {dat[3], dat[2], dat[1], dat[0]};
        rst     = 1'b0;
        q_empty = 4'h0;
        out_rdy = 1'b1;

        // Reset held with every queue non-empty.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_pop", 32'(q_pop), 32'h0);
            check("rst_vld", 32'(out_vld), 32'h0);
        end
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_qid", 32'(out_qid), 32'h0);

        // Release, then full rotation 0,1,2,3,0,1,2.
        rst = 1'b1;
        #1;
        check("rel_pop", 32'(q_pop), 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_out("rot", (k - 1) % 4);
            check("rot_pop", 32'(q_pop), 32'(1 << (k % 4)));
        end

        // Skip empties: move rr_ptr to 1, then only queues 0 and 2 request.
        do_reset();
        q_empty = 4'b1110;
        #1;
        check("skip_pre_pop", 32'(q_pop), 32'h1);
        tick();
        check_out("skip_pre", 0);
        q_empty = 4'b1010;
        grants = '{2, 0, 2, 0};
        for (int j = 0; j < 4; j++) begin
            #1;
            check("skip_pop", 32'(q_pop), 32'(1 << grants[j]));
            tick();
            check_out("skip", grants[j]);
        end
        q_empty = 4'hF;
        #1;
        check("skip_idle_pop", 32'(q_pop), 32'h0);

        // Backpressure: 0xA5 from queue 2 held while out_rdy is low.
        q_empty = 4'b1011;
        #1;
        check("bp_load_pop", 32'(q_pop), 32'h4);
        tick();
        check_out("bp_load", 2);
        out_rdy = 1'b0;
        q_empty = 4'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_pop", 32'(q_pop), 32'h0);
            check_out("bp_hold", 2);
            tick();
        end
        out_rdy = 1'b1;
        #1;
        check("bp_rel_pop", 32'(q_pop), 32'h8);
        tick();
        check_out("bp_next", 3);

        // Drain to idle: one word in queue 1.
        q_empty = 4'b1101;
        #1;
        check("drain_pop", 32'(q_pop), 32'h2);
        tick();
        check_out("drain", 1);
        q_empty = 4'hF;
        #1;
        check("drain_idle_pop", 32'(q_pop), 32'h0);
        tick();
        check("drain_vld0", 32'(out_vld), 32'h0);
        check("drain_hold_data", 32'(out_data), 32'h22);
        check("drain_hold_qid", 32'(out_qid), 32'h1);
        tick();
        check("drain_vld1", 32'(out_vld), 32'h0);
        q_empty = 4'h0;
        #1;
        check("drain_ptr_pop", 32'(q_pop), 32'h4);

        // Asynchronous reset in the middle of a stall.
        out_rdy = 1'b0;
        tick();
        check_out("ar_load", 2);
        check("ar_stall_pop", 32'(q_pop), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_vld", 32'(out_vld), 32'h0);
        check("ar_data", 32'(out_data), 32'h0);
        check("ar_qid", 32'(out_qid), 32'h0);
        check("ar_pop", 32'(q_pop), 32'h0);
        tick();
        rst     = 1'b1;
        out_rdy = 1'b1;
        #1;
        check("ar_rel_pop", 32'(q_pop), 32'h1);
        tick();
        check_out("ar_first", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin drain stage sitting directly downstream of a bank of `fifo` instances in the arbitrated-FIFO design. It watches each FIFO's `empty` flag and first-word `data_out`, and issues at most one `pop` per cycle to the granted queue. The popped word goes into a single output register with a valid/ready handshake, tagged with its queue index. Fairness comes from a rotating priority pointer: no non-empty queue waits more than NQ-1 grants.

## Interface
- `WIDTH`, default `FIFO_DWIDTH: data word width; equals the upstream FIFO width.
- `QWID`, default `ARB_QWID: queue-index width.
- `NQ`, default 2**QWID: number of upstream FIFOs; must satisfy 2 <= NQ <= 2**QWID.

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `q_empty`  in  NQ  per-queue `empty` from each FIFO.
- `q_data`  in  NQ*WIDTH  per-queue first-word `data_out`; queue i occupies bits [i*WIDTH +: WIDTH].
- `q_pop`  out  NQ  one-hot-or-zero pop strobe to the FIFOs; combinational.
- `out_vld`  out  1  output register holds a valid word.
- `out_rdy`  in  1  consumer accepts the word this cycle.
- `out_data`  out  WIDTH  registered word.
- `out_qid`  out  QWID  index of the queue `out_data` came from.

## Operation
- State:
  - `rr_ptr` [QWID-1:0]: highest-priority queue index.
  - Output register: `out_vld`, `out_data`, `out_qid`.
- `slot_free` = !out_vld || out_rdy.
- `req[i]` = !q_empty[i].
- Grant selection:
  - `gnt` = first i with req[i] set, searching rr_ptr, rr_ptr+1, …, NQ-1, then 0, …, rr_ptr-1.
  - `any_req` = |req.
- `load` = slot_free && any_req.
- `q_pop[gnt]` = load; all other bits 0. `q_pop` is 0 whenever `rst` is low.
- On posedge with `load`:
  - out_data <= q_data[gnt]; out_qid <= gnt; out_vld <= 1.
  - rr_ptr <= (gnt == NQ-1) ? 0 : gnt+1. The wrap is explicit, not modulo 2**QWID, so non-power-of-two NQ works.
- On posedge with out_vld && out_rdy && !load: out_vld <= 0; out_data and out_qid hold their values.
- Otherwise all state holds. rr_ptr changes only on a grant.
- Stall: while out_vld && !out_rdy, `q_pop` = 0 and `out_data`/`out_qid` are stable.
- Simultaneous accept and load: the old word is consumed and the new word is captured on the same edge. Throughput is one word per cycle.
- `q_data` of a non-granted queue is never sampled. No pop is issued to a queue whose `q_empty` is 1.

## Timing
- Reset (rst low, asynchronous): out_vld=0, out_data=0, out_qid=0, rr_ptr=0, q_pop=0 immediately, without waiting for a clock edge. Release is synchronous to the next posedge.
- Reset asserted mid-transfer: a held word is discarded and nothing is popped. Upstream FIFOs are reset by the same `rst`.
- Latency: q_empty[i] falling at cycle n, with the slot free and i winning arbitration, gives q_pop[i]=1 in cycle n and out_vld=1 with the word from cycle n+1.
- Combinational paths:
  - q_empty, out_rdy → q_pop: combinational.
  - q_data → out_data: registered.
  - No combinational path from q_empty or q_data to out_vld, out_data or out_qid.
- Fairness bound: a queue with q_empty=0 continuously is granted within NQ consecutive loads.

## Test plan
- Reset: hold rst=0 with q_empty=0 on all queues → q_pop=0 and out_vld=0 throughout. Deassert rst with out_rdy=1 → q_pop=0001 on the first cycle, out_qid=0 the cycle after.
- Full rotation: NQ=4, all queues non-empty, out_rdy=1 constantly → grants 0,1,2,3,0,1 on consecutive cycles. rr_ptr wraps 3→0. One word per cycle.
- Skip empties: q_empty=4'b1010, rr_ptr=1 → grants 2,0,2,0. q_pop is never set on bits 1 or 3.
- Backpressure: load word 0xA5 from queue 2, then hold out_rdy=0 for 5 cycles with all queues non-empty → q_pop=0 and out_data=0xA5/out_qid=2 stable. When out_rdy rises, the next grant is queue 3 in that same cycle.
- Drain to idle: single word in queue 1, out_rdy=1 → out_vld high for exactly 1 cycle, then 0 with out_data held. rr_ptr=2.
- Async reset mid-stall: out_vld=1, out_rdy=0, pull rst low between edges → out_vld=0, out_data=0 and q_pop=0 before the next posedge. After release, arbitration restarts at queue 0.
